stopwatch_lap_core: RTL and testbench

//  Parametrised stopwatch engine: prescaled 1/TICK_HZ time base, hh:mm:ss.cc counter, and a lap-record FIFO

---
 rtl/stopwatch_lap_core.sv | 189 ++++++++++++++++++
 tb/tb_stopwatch_lap_core.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core: prescaled hh:mm:ss.cc stopwatch engine feeding a first-word fall-through lap FIFO.
// Optional STOPWATCH_COUNTDOWN_EN adds preset load, count-down with borrow and a one-cycle expiry pulse.
module stopwatch_lap_core #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 100,
    parameter int LAP_DEPTH = 8,
    parameter int HOUR_MAX  = 99
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start_pause,
    input  logic                           lap,
    input  logic                           clear_timer,
    input  logic                           lap_flush,
    input  logic                           lap_ready,
`ifdef STOPWATCH_COUNTDOWN_EN
    input  logic                           load,
    input  logic [27:0]                    preset,
    input  logic                           count_down,
    output logic                           expired,
`endif
    output logic                           running,
    output logic [27:0]                    timestamp,
    output logic                           tick,
    output logic                           rollover,
    output logic                           lap_valid,
    output logic [27:0]                    lap_data,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_count,
    output logic                           lap_overflow
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PS_W     = $clog2(PRESCALE);
    localparam int PW       = $clog2(LAP_DEPTH);
    localparam int CW       = $clog2(LAP_DEPTH + 1);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [6:0]      CMAX    = 7'(TICK_HZ - 1);
    localparam logic [6:0]      HMAX    = 7'(HOUR_MAX);
    localparam logic [6:0]      L59     = 7'd59;

    typedef struct packed {
        logic [6:0] hour;
        logic [6:0] minute;
        logic [6:0] second;
        logic [6:0] csec;
    } ts_t;

    ts_t             ts_q, ts_inc, ts_nxt, ld_val;
    logic [PS_W-1:0] ps_q;
    logic            run_nxt, down, ld, stop;

    logic [27:0]     mem [LAP_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            full, push_ok, pop;

    assign tick      = running && (ps_q == PS_LAST);
    assign timestamp = ts_q;
    assign rollover  = tick && !down && (ts_q == ts_t'{HMAX, L59, L59, CMAX});

    always_comb begin
        ts_inc = ts_q;
        if (ts_q.csec != CMAX) ts_inc.csec = ts_q.csec + 7'd1;
        else begin
            ts_inc.csec = '0;
            if (ts_q.second != L59) ts_inc.second = ts_q.second + 7'd1;
            else begin
                ts_inc.second = '0;
                if (ts_q.minute != L59) ts_inc.minute = ts_q.minute + 7'd1;
                else begin
                    ts_inc.minute = '0;
                    ts_inc.hour   = (ts_q.hour != HMAX) ? ts_q.hour + 7'd1 : 7'd0;
                end
            end
        end
    end

`ifdef STOPWATCH_COUNTDOWN_EN
    ts_t  ts_dec;
    logic is_zero, hit_zero;

    assign down     = count_down;
    assign ld       = load;
    assign ld_val   = ts_t'(preset);
    assign is_zero  = (ts_q == '0);
    // Only a decrement that actually lands on zero expires; load/clear suppress the tick.
    assign hit_zero = down && tick && !ld && !clear_timer && (ts_q == ts_t'(28'd1));
    assign stop     = down && tick && !ld && !clear_timer && (is_zero || ts_q == ts_t'(28'd1));

    always_comb begin
        ts_dec = ts_q;
        if (ts_q.csec != '0) ts_dec.csec = ts_q.csec - 7'd1;
        else begin
            ts_dec.csec = CMAX;
            if (ts_q.second != '0) ts_dec.second = ts_q.second - 7'd1;
            else begin
                ts_dec.second = L59;
                if (ts_q.minute != '0) ts_dec.minute = ts_q.minute - 7'd1;
                else begin
                    ts_dec.minute = L59;
                    ts_dec.hour   = (ts_q.hour != '0) ? ts_q.hour - 7'd1 : HMAX;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) expired <= 1'b0;
        else          expired <= hit_zero;
    end
`else
    assign down   = 1'b0;
    assign ld     = 1'b0;
    assign ld_val = '0;
    assign stop   = 1'b0;
`endif

    always_comb begin
        ts_nxt = ts_q;
        if (ld)               ts_nxt = ld_val;
        else if (clear_timer) ts_nxt = '0;
        else if (tick) begin
`ifdef STOPWATCH_COUNTDOWN_EN
            if (down) ts_nxt = is_zero ? ts_q : ts_dec;
            else      ts_nxt = ts_inc;
`else
            ts_nxt = ts_inc;
`endif
        end
    end

    always_comb begin
        run_nxt = running;
`ifdef STOPWATCH_COUNTDOWN_EN
        if (start_pause && !(!running && down && is_zero)) run_nxt = !running;
`else
        if (start_pause) run_nxt = !running;
`endif
        if (stop) run_nxt = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            running <= 1'b0;
            ps_q    <= '0;
            ts_q    <= '0;
        end else begin
            running <= run_nxt;
            ts_q    <= ts_nxt;
            if (ld || clear_timer) ps_q <= '0;
            else if (running)      ps_q <= tick ? '0 : ps_q + 1'b1;
        end
    end

    // Lap FIFO: flush dominates; a full FIFO still accepts a push when the same cycle pops.
    assign lap_valid = (lap_count != '0);
    assign full      = (lap_count == CW'(LAP_DEPTH));
    assign pop       = lap_valid && lap_ready && !lap_flush;
    assign push_ok   = lap && !lap_flush && (!full || pop);
    assign lap_data  = lap_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= ts_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_count    <= '0;
            lap_overflow <= 1'b0;
        end else if (lap_flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            lap_count    <= '0;
            lap_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   lap_count <= lap_count + 1'b1;
                2'b01:   lap_count <= lap_count - 1'b1;
                default: lap_count <= lap_count;
            endcase
            if (lap && !push_ok) lap_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core: main instance at 10-cycle prescale, second fast instance for hour rollover.
module tb_stopwatch_lap_core;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_pause = 1'b0, lap = 1'b0, clear_timer = 1'b0, lap_flush = 1'b0, lap_ready = 1'b0;
    logic        running, tick, rollover, lap_valid, lap_overflow;
    logic [27:0] timestamp, lap_data;
    logic [2:0]  lap_count;
`ifdef STOPWATCH_COUNTDOWN_EN
    logic        load = 1'b0, count_down = 1'b0, expired, r_expired;
    logic [27:0] preset = '0;
`endif

    logic        r_sp = 1'b0;
    logic        r_running, r_tick, r_rollover, r_lap_valid, r_lap_overflow;
    logic [27:0] r_ts, r_lap_data;
    logic [1:0]  r_lap_count;

    int checks = 0, errors = 0;
    int tick_cnt = 0, roll_cnt = 0, t0, rc0;

    always #5 clock = ~clock;

    stopwatch_lap_core #(.CLK_HZ(1000), .TICK_HZ(100), .LAP_DEPTH(4), .HOUR_MAX(1)) dut (
        .clock(clock), .reset_n(reset_n), .start_pause(start_pause), .lap(lap),
        .clear_timer(clear_timer), .lap_flush(lap_flush), .lap_ready(lap_ready),
`ifdef STOPWATCH_COUNTDOWN_EN
        .load(load), .preset(preset), .count_down(count_down), .expired(expired),
`endif
        .running(running), .timestamp(timestamp), .tick(tick), .rollover(rollover),
        .lap_valid(lap_valid), .lap_data(lap_data), .lap_count(lap_count), .lap_overflow(lap_overflow)
    );

    // 2-cycle prescale, whole-second ticks: reaches 1:59:59 in 7199 ticks.
    stopwatch_lap_core #(.CLK_HZ(2), .TICK_HZ(1), .LAP_DEPTH(2), .HOUR_MAX(1)) u_roll (
        .clock(clock), .reset_n(reset_n), .start_pause(r_sp), .lap(1'b0),
        .clear_timer(1'b0), .lap_flush(1'b0), .lap_ready(1'b0),
`ifdef STOPWATCH_COUNTDOWN_EN
        .load(1'b0), .preset(28'd0), .count_down(1'b0), .expired(r_expired),
`endif
        .running(r_running), .timestamp(r_ts), .tick(r_tick), .rollover(r_rollover),
        .lap_valid(r_lap_valid), .lap_data(r_lap_data), .lap_count(r_lap_count), .lap_overflow(r_lap_overflow)
    );

    always @(negedge clock) begin
        if (tick)       tick_cnt <= tick_cnt + 1;
        if (r_rollover) roll_cnt <= roll_cnt + 1;
    end

    function automatic logic [27:0] tsv(int h, int m, int s, int c);
        return {7'(h), 7'(m), 7'(s), 7'(c)};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_running", 32'(running), 0);
        chk("rst_ts", 32'(timestamp), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_valid", 32'(lap_valid), 0);
        chk("rst_count", 32'(lap_count), 0);
        chk("rst_ovf", 32'(lap_overflow), 0);
        chk("rst_data", 32'(lap_data), 0);
        reset_n = 1'b1;

        // 1000 running cycles -> 100 ticks -> 0:00:01.00
        start_pause = 1'b1; cyc(); start_pause = 1'b0;
        t0 = tick_cnt;
        chk("run_on", 32'(running), 1);
        repeat (1000) cyc();
        chk("ts_1s", 32'(timestamp), 32'(tsv(0, 0, 1, 0)));
        chk("ticks_100", 32'(tick_cnt - t0), 100);

        // pause with prescaler held at 4, resume -> tick on 6th running cycle
        repeat (3) cyc();
        start_pause = 1'b1; cyc(); start_pause = 1'b0;
        chk("paused", 32'(running), 0);
        repeat (50) cyc();
        chk("ts_hold", 32'(timestamp), 32'(tsv(0, 0, 1, 0)));
        chk("ticks_hold", 32'(tick_cnt - t0), 100);
        start_pause = 1'b1; cyc(); start_pause = 1'b0;
        chk("resume_tick_c1", 32'(tick), 0);
        repeat (4) cyc();
        chk("resume_tick_c5", 32'(tick), 0);
        cyc();
        chk("resume_tick_c6", 32'(tick), 1);
        cyc();
        chk("ts_after_resume", 32'(timestamp), 32'(tsv(0, 0, 1, 1)));

        // five laps 10 cycles apart, no consumer: fifth is dropped
        for (int k = 1; k <= 5; k++) begin
            lap = 1'b1; cyc(); lap = 1'b0;
            if (k == 1) begin
                chk("lap_lat_valid", 32'(lap_valid), 1);
                chk("lap_lat_data", 32'(lap_data), 32'(tsv(0, 0, 1, 1)));
            end
            repeat (9) cyc();
        end
        chk("full_count", 32'(lap_count), 4);
        chk("full_ovf", 32'(lap_overflow), 1);
        start_pause = 1'b1; cyc(); start_pause = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("drain_order", 32'(lap_data), 32'(tsv(0, 0, 1, k)));
            lap_ready = 1'b1; cyc(); lap_ready = 1'b0;
        end
        chk("drained_valid", 32'(lap_valid), 0);
        chk("ovf_sticky", 32'(lap_overflow), 1);
        lap_ready = 1'b1; cyc(); lap_ready = 1'b0;
        chk("pop_empty", 32'(lap_count), 0);
        lap_flush = 1'b1; lap = 1'b1; cyc(); lap_flush = 1'b0; lap = 1'b0;
        chk("flush_count", 32'(lap_count), 0);
        chk("flush_ovf", 32'(lap_overflow), 0);

        // lap + clear same cycle stores pre-clear value
        lap = 1'b1; clear_timer = 1'b1; cyc(); lap = 1'b0; clear_timer = 1'b0;
        chk("clr_ts", 32'(timestamp), 0);
        chk("clr_count", 32'(lap_count), 1);
        chk("clr_entry", 32'(lap_data), 32'(tsv(0, 0, 1, 6)));
        repeat (3) begin lap = 1'b1; cyc(); lap = 1'b0; end
        chk("refill", 32'(lap_count), 4);
        start_pause = 1'b1; cyc(); start_pause = 1'b0;
        repeat (10) cyc();
        start_pause = 1'b1; cyc(); start_pause = 1'b0;
        chk("ts_0_01", 32'(timestamp), 32'(tsv(0, 0, 0, 1)));

        // push + pop on full FIFO: both accepted
        lap = 1'b1; lap_ready = 1'b1; cyc(); lap = 1'b0; lap_ready = 1'b0;
        chk("pp_count", 32'(lap_count), 4);
        chk("pp_ovf", 32'(lap_overflow), 0);
        for (int k = 0; k < 4; k++) begin
            chk("pp_order", 32'(lap_data), (k == 3) ? 32'(tsv(0, 0, 0, 1)) : 32'd0);
            lap_ready = 1'b1; cyc(); lap_ready = 1'b0;
        end
        chk("pp_empty", 32'(lap_valid), 0);

        // hour-range rollover on the fast instance
        r_sp = 1'b1; cyc(); r_sp = 1'b0;
        rc0 = roll_cnt;
        repeat (14398) cyc();
        chk("roll_pre_ts", 32'(r_ts), 32'(tsv(1, 59, 59, 0)));
        chk("roll_none_yet", 32'(roll_cnt - rc0), 0);
        cyc();
        chk("roll_tick", 32'(r_tick), 1);
        chk("roll_pulse", 32'(r_rollover), 1);
        cyc();
        chk("roll_ts0", 32'(r_ts), 0);
        chk("roll_pulse_off", 32'(r_rollover), 0);
        chk("roll_running", 32'(r_running), 1);
        chk("roll_once", 32'(roll_cnt - rc0), 1);

`ifdef STOPWATCH_COUNTDOWN_EN
        load = 1'b1; preset = tsv(0, 0, 0, 3); count_down = 1'b1; cyc(); load = 1'b0;
        chk("cd_load", 32'(timestamp), 32'(tsv(0, 0, 0, 3)));
        start_pause = 1'b1; cyc(); start_pause = 1'b0;
        t0 = tick_cnt;
        repeat (29) cyc();
        chk("cd_ts1", 32'(timestamp), 1);
        cyc();
        chk("cd_ts0", 32'(timestamp), 0);
        chk("cd_stop", 32'(running), 0);
        chk("cd_expired", 32'(expired), 1);
        chk("cd_ticks", 32'(tick_cnt - t0), 3);
        cyc();
        chk("cd_exp_pulse", 32'(expired), 0);
        start_pause = 1'b1; cyc(); start_pause = 1'b0;
        chk("cd_start_ign", 32'(running), 0);
        count_down = 1'b0;
`endif

        // reset mid-operation discards FIFO
        lap = 1'b1; cyc(); lap = 1'b0;
        chk("pre_rst_valid", 32'(lap_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(lap_valid), 0);
        chk("mid_rst_count", 32'(lap_count), 0);
        reset_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
